// File: rtl/conv3x3_mac.sv
// conv3x3_mac: KX*KY convolution MAC stage fed by the line-buffer window
// controller. A signed kernel plus bias is loaded serially. Each accepted
// window is multiplied by the kernel, summed, biased, shifted and saturated.
// The result comes out as one B-bit pixel, exactly 3 cycles after acceptance.
//
// Optional feature macro: CONV_RELU_EN
//   defined   -> result clamped to [0, 2^B-1] (ReLU, unsigned output)
//   undefined -> result saturated to signed B-bit range (two's complement)
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_pixel_data[_valid]   KX*KY*B window, pixel k at [k*B +: B]
//   i_wgt_data/_valid      serial kernel words: KX*KY weights, then the bias
//   i_wgt_reload           request to drain the pipeline and reload the kernel
//   o_wgt_ready            kernel loaded, windows are accepted
//   o_conv_data[_valid]    result pixel and its strobe
//   o_row_done             high with the last output of a row (F-KX+1 outputs)
//   o_busy                 any pipeline stage holds valid data

// One multiplier lane: unsigned pixel times signed weight.
module conv3x3_mac_lane #(
  parameter int B   = 8,
  parameter int W_B = 8
) (
  input  logic [B-1:0]   i_pix,
  input  logic [W_B-1:0] i_wgt,
  output logic [B+W_B:0] o_prod
);
  localparam int P_W = B + W_B + 1;

  logic signed [P_W-1:0] pix_s, wgt_s, prod_s;

  // Zero-extend the pixel into a signed operand, sign-extend the weight.
  assign pix_s  = P_W'(signed'({1'b0, i_pix}));
  assign wgt_s  = P_W'(signed'(i_wgt));
  assign prod_s = pix_s * wgt_s;
  assign o_prod = prod_s;
endmodule

module conv3x3_mac #(
  parameter int F     = 28,
  parameter int B     = 8,
  parameter int W_B   = 8,
  parameter int KX    = 3,
  parameter int KY    = 3,
  parameter int ACC_B = 21,
  parameter int SHIFT = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [KX*KY*B-1:0]   i_pixel_data,
  input  logic                 i_pixel_data_valid,
  input  logic [W_B-1:0]       i_wgt_data,
  input  logic                 i_wgt_valid,
  input  logic                 i_wgt_reload,
  output logic                 o_wgt_ready,
  output logic [B-1:0]         o_conv_data,
  output logic                 o_conv_data_valid,
  output logic                 o_row_done,
  output logic                 o_busy
);
  localparam int NTAP   = KX * KY;
  localparam int P_W    = B + W_B + 1;
  localparam int IDX_W  = $clog2(NTAP + 1);
  localparam int STAGES = 3;
  // One extra bit so sum + bias cannot wrap before saturation.
  localparam int R_W    = ACC_B + 1;
  localparam int CNT_W  = $clog2(F - KX + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(F - KX);
  localparam logic [IDX_W-1:0] IDX_BIAS = IDX_W'(NTAP);

`ifdef CONV_RELU_EN
  localparam logic signed [R_W-1:0] SAT_HI = R_W'((1 << B) - 1);
`else
  localparam logic signed [R_W-1:0] SAT_HI = R_W'((1 << (B - 1)) - 1);
  localparam logic signed [R_W-1:0] SAT_LO = R_W'(-(1 << (B - 1)));
`endif

  typedef enum logic [1:0] {ST_LOAD, ST_READY, ST_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NTAP-1:0][W_B-1:0]   wgt_q, wgt_d;
  logic [W_B-1:0]             bias_q, bias_d;

  // vld_pipe[0] is the accept strobe, [STAGES:1] are the stage flags.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:1]            vld_q, vld_d;

  logic [NTAP-1:0][P_W-1:0]   lane_prod;
  logic [NTAP-1:0][P_W-1:0]   prod_q, prod_d;
  logic signed [ACC_B-1:0]    sum_q, sum_d;
  logic [B-1:0]               conv_q, conv_d;
  logic                       row_done_q, row_done_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  logic                       accept, busy, drain_clr;
  logic signed [R_W-1:0]      biased, shifted;
  logic [B-1:0]               sat;

  assign accept   = i_pixel_data_valid && (state_q == ST_READY);
  assign busy     = |vld_q;
  // Drain finished: back to LOAD, counters cleared.
  assign drain_clr = (state_q == ST_DRAIN) && !busy;

  assign vld_pipe[0]        = accept;
  assign vld_pipe[STAGES:1] = vld_q;
  assign vld_d              = vld_pipe[STAGES-1:0];

  // ---------------- multiplier lanes ----------------
  genvar k;
  generate
    for (k = 0; k < NTAP; k++) begin : g_lane
      conv3x3_mac_lane #(.B(B), .W_B(W_B)) u_lane (
        .i_pix  (i_pixel_data[k*B +: B]),
        .i_wgt  (wgt_q[k]),
        .o_prod (lane_prod[k])
      );
    end
  endgenerate

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wgt_d   = wgt_q;
    bias_d  = bias_q;
    case (state_q)
      ST_LOAD: begin
        if (i_wgt_valid) begin
          if (idx_q == IDX_BIAS) begin
            bias_d  = i_wgt_data;
            state_d = ST_READY;
          end else begin
            wgt_d[idx_q] = i_wgt_data;
          end
          idx_d = idx_q + 1'b1;
        end
      end
      ST_READY: begin
        if (i_wgt_reload) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_clr) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------- S3 arithmetic ----------------
  always_comb begin
    biased  = R_W'(sum_q) + R_W'(signed'(bias_q));
    shifted = biased >>> SHIFT;
`ifdef CONV_RELU_EN
    if (shifted[R_W-1])          sat = '0;
    else if (shifted > SAT_HI)   sat = '1;
    else                         sat = shifted[B-1:0];
`else
    if (shifted > SAT_HI)        sat = {1'b0, {(B-1){1'b1}}};
    else if (shifted < SAT_LO)   sat = {1'b1, {(B-1){1'b0}}};
    else                         sat = shifted[B-1:0];
`endif
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    prod_d     = accept ? lane_prod : prod_q;
    sum_d      = sum_q;
    if (vld_q[1]) begin
      sum_d = '0;
      for (int t = 0; t < NTAP; t++)
        sum_d = sum_d + ACC_B'(signed'(prod_q[t]));
    end
    conv_d     = vld_q[2] ? sat : conv_q;
    row_done_d = vld_q[2] && (cnt_q == CNT_MAX);
    cnt_d      = cnt_q;
    if (vld_q[2]) cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    if (drain_clr) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      wgt_q      <= '0;
      bias_q     <= '0;
      vld_q      <= '0;
      prod_q     <= '0;
      sum_q      <= '0;
      conv_q     <= '0;
      row_done_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wgt_q      <= wgt_d;
      bias_q     <= bias_d;
      vld_q      <= vld_d;
      prod_q     <= prod_d;
      sum_q      <= sum_d;
      conv_q     <= conv_d;
      row_done_q <= row_done_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_wgt_ready       = (state_q == ST_READY);
  assign o_conv_data       = conv_q;
  assign o_conv_data_valid = vld_pipe[STAGES];
  assign o_row_done        = row_done_q;
  assign o_busy            = busy;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Directed bench for conv3x3_mac: kernel load, basic MAC, saturation,
// reload drain, mid-stream reset and row_done over two full rows.
module tb_conv3x3_mac;
  localparam int B  = 8;
  localparam int NT = 9;

`ifdef CONV_RELU_EN
  localparam logic [7:0] SAT_POS = 8'hFF;
  localparam logic [7:0] NEG85   = 8'h00;
`else
  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] NEG85   = 8'hAB;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NT*B-1:0]   pix;
  logic              pix_vld;
  logic [7:0]        wgt;
  logic              wgt_vld;
  logic              reload;
  logic              wgt_ready;
  logic [7:0]        conv;
  logic              conv_vld;
  logic              row_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv3x3_mac dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_pixel_data       (pix),
    .i_pixel_data_valid (pix_vld),
    .i_wgt_data         (wgt),
    .i_wgt_valid        (wgt_vld),
    .i_wgt_reload       (reload),
    .o_wgt_ready        (wgt_ready),
    .o_conv_data        (conv),
    .o_conv_data_valid  (conv_vld),
    .o_row_done         (row_done),
    .o_busy             (busy)
  );

  function automatic logic [NT*B-1:0] win(input logic [7:0] v);
    logic [NT*B-1:0] r;
    r = '0;
    for (int i = 0; i < NT; i++) r[i*B +: B] = v;
    return r;
  endfunction

  // Stimulus only: nine identical weights then the bias, from LOAD state.
  task automatic load_kernel(input logic [7:0] w, input logic [7:0] b);
    for (int i = 0; i <= NT; i++) begin
      @(negedge clk);
      wgt_vld = 1'b1;
      wgt     = (i == NT) ? b : w;
    end
    @(negedge clk);
    wgt_vld = 1'b0;
    wgt     = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pix = '0; pix_vld = 0; wgt = '0; wgt_vld = 0; reload = 0;
    repeat (2) @(negedge clk);
    checks++; if (wgt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", wgt_ready); end
    checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", conv_vld); end
    checks++; if (conv !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", conv); end
    checks++; if (row_done !== 1'b0) begin errors++; $display("FAIL reset_row_done: got %b want 0", row_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
  endtask

  // Load ones / bias 0 while windows are offered (they must be ignored).
  task automatic test_load();
    for (int i = 0; i <= NT; i++) begin
      @(negedge clk);
      checks++; if (wgt_ready !== 1'b0) begin errors++; $display("FAIL load_ready_early[%0d]: got %b want 0", i, wgt_ready); end
      checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL load_window_ignored[%0d]: got %b want 0", i, conv_vld); end
      wgt_vld = 1'b1;
      wgt     = (i == NT) ? 8'h00 : 8'h01;
      pix_vld = 1'b1;
      pix     = win(8'd7);
    end
    @(negedge clk);
    wgt_vld = 1'b0; pix_vld = 1'b0;
    checks++; if (wgt_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", wgt_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL load_no_output[%0d]: got %b want 0", i, conv_vld); end
    end
  endtask

  // Single window, check latency 3, single-cycle strobe and data hold.
  task automatic test_single(input string nm, input logic [7:0] pv, input logic [7:0] exp);
    @(negedge clk);
    pix = win(pv); pix_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        pix_vld = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", nm, busy); end
      end
      checks++; if (conv_vld !== (i == 2)) begin errors++; $display("FAIL %s_valid[%0d]: got %b want %b", nm, i, conv_vld, (i == 2)); end
      if (i >= 2) begin
        checks++; if (conv !== exp) begin errors++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, conv, exp); end
      end
    end
  endtask

  task automatic test_basic();
    test_single("basic", 8'd10, 8'd90);
  endtask

  task automatic test_saturate();
    test_single("saturate", 8'd255, SAT_POS);
  endtask

  // Reload with two windows in flight: old kernel results, then drain, reload.
  task automatic test_reload();
    int n;
    @(negedge clk); pix = win(8'd10);  pix_vld = 1'b1;
    @(negedge clk); pix = win(8'd255); reload  = 1'b1;
    @(negedge clk); pix = win(8'd50);  reload  = 1'b0;
    checks++; if (wgt_ready !== 1'b0) begin errors++; $display("FAIL reload_ready_low: got %b want 0", wgt_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reload_busy: got %b want 1", busy); end
    @(negedge clk); pix_vld = 1'b0;
    checks++; if (conv_vld !== 1'b1 || conv !== 8'd90) begin errors++; $display("FAIL reload_old0: got v=%b d=%h want v=1 d=5a", conv_vld, conv); end
    @(negedge clk);
    checks++; if (conv_vld !== 1'b1 || conv !== SAT_POS) begin errors++; $display("FAIL reload_old1: got v=%b d=%h want v=1 d=%h", conv_vld, conv, SAT_POS); end
    @(negedge clk);
    checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL reload_drain_window: got %b want 0", conv_vld); end
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL reload_busy_timeout: got busy=%b want 0", busy); end
    checks++; if (wgt_ready !== 1'b0) begin errors++; $display("FAIL reload_ready_drain: got %b want 0", wgt_ready); end
    load_kernel(8'hFF, 8'd5);
    checks++; if (wgt_ready !== 1'b1) begin errors++; $display("FAIL reload_ready_new: got %b want 1", wgt_ready); end
  endtask

  // Kernel -1, bias 5: back-to-back windows 10 and 0.
  task automatic test_negative();
    @(negedge clk); pix = win(8'd10); pix_vld = 1'b1;
    @(negedge clk); pix = win(8'd0);
    @(negedge clk); pix_vld = 1'b0;
    @(negedge clk);
    checks++; if (conv_vld !== 1'b1 || conv !== NEG85) begin errors++; $display("FAIL negative_85: got v=%b d=%h want v=1 d=%h", conv_vld, conv, NEG85); end
    @(negedge clk);
    checks++; if (conv_vld !== 1'b1 || conv !== 8'd5) begin errors++; $display("FAIL negative_bias: got v=%b d=%h want v=1 d=05", conv_vld, conv); end
    @(negedge clk);
    checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL negative_end: got %b want 0", conv_vld); end
  endtask

  // One-cycle reset while streaming: in-flight results discarded.
  task automatic test_rst_mid();
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j >= 3) begin
        checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL rstmid_valid[%0d]: got %b want 0", j, conv_vld); end
        checks++; if (wgt_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready[%0d]: got %b want 0", j, wgt_ready); end
      end
      if (j == 3) begin
        checks++; if (conv !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", conv); end
      end
      pix = win(8'd20); pix_vld = 1'b1;
      rst_n = (j == 2) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    pix_vld = 1'b0;
    checks++; if (conv_vld !== 1'b0) begin errors++; $display("FAIL rstmid_final: got %b want 0", conv_vld); end
  endtask

  // 52 windows back to back with kernel ones: row_done on outputs 26 and 52.
  task automatic test_stream();
    logic [7:0] exp;
    int o;
    load_kernel(8'h01, 8'h00);
    checks++; if (wgt_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b want 1", wgt_ready); end
    for (int j = 0; j < 57; j++) begin
      @(negedge clk);
      o = j - 3;
      if (o >= 0 && o < 52) begin
        exp = 8'(9 * (o % 14));
        checks++; if (conv_vld !== 1'b1 || conv !== exp) begin errors++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", o, conv_vld, conv, exp); end
        checks++; if (row_done !== (o == 25 || o == 51)) begin errors++; $display("FAIL stream_row_done[%0d]: got %b want %b", o, row_done, (o == 25 || o == 51)); end
      end else begin
        checks++; if (conv_vld !== 1'b0 || row_done !== 1'b0) begin errors++; $display("FAIL stream_idle[%0d]: got v=%b rd=%b want 0 0", j, conv_vld, row_done); end
      end
      if (j < 52) begin
        pix = win(8'(j % 14)); pix_vld = 1'b1;
      end else begin
        pix_vld = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_basic();
    test_saturate();
    test_reload();
    test_negative();
    test_rst_mid();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
